// File: rtl/ntt_result_uart_sender.sv
// Buffers one RADIX-word NTT result frame, then streams it little-endian, byte by byte,
// to a uart_tx byte interface, rearming for the next frame once the last byte completes.
module ntt_result_uart_sender #(
    parameter int W     = 32,
    parameter int RADIX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         result_valid_i,
    input  logic [W-1:0] result_data_i,
    input  logic         tx_active_i,
    input  logic         tx_done_i,
    output logic         tx_dv_o,
    output logic [7:0]   tx_byte_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         overflow_o
);
    localparam int BYTES = W / 8;
    localparam int RW    = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [RW-1:0] LAST_WORD = RW'(RADIX - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

    typedef enum logic [1:0] {S_CAPTURE, S_SEND, S_WAIT, S_FINISH} state_t;

    state_t          r_state, w_state_next;
    logic [W-1:0]    r_buf [RADIX];
    logic [RW-1:0]   r_wr_idx, w_wr_idx_next;
    logic [RW-1:0]   r_rd_idx, w_rd_idx_next;
    logic [BW-1:0]   r_byte_idx, w_byte_idx_next;
    logic            r_tx_dv, w_tx_dv_next;
    logic [7:0]      r_tx_byte, w_tx_byte_next;
    logic            r_busy, w_busy_next;
    logic            r_done, w_done_next;
    logic            r_overflow, w_overflow_next;
    logic            w_buf_we;
    logic [W-1:0]    w_rd_word;
    logic [W-1:0]    w_rd_shifted;

    assign w_rd_word    = r_buf[r_rd_idx];
    assign w_rd_shifted = w_rd_word >> {r_byte_idx, 3'b000};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of process ordering in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CAPTURE;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_byte_idx <= '0;
            r_tx_dv    <= 1'b0;
            r_tx_byte  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wr_idx   <= w_wr_idx_next;
            r_rd_idx   <= w_rd_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_tx_dv    <= w_tx_dv_next;
            r_tx_byte  <= w_tx_byte_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_overflow <= w_overflow_next;
        end
    end

    // NOTE: the frame buffer is deliberately not reset; it is always fully rewritten
    // before being read, so a reset would only cost a wide reset network.
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_idx] <= result_data_i;
        end
    end

    // NOTE: each always_comb assigns a default to every output first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_CAPTURE: if (result_valid_i && r_wr_idx == LAST_WORD) w_state_next = S_SEND;
            S_SEND:    if (!tx_active_i) w_state_next = S_WAIT;
            S_WAIT: begin
                if (tx_done_i) begin
                    if (r_byte_idx == LAST_BYTE && r_rd_idx == LAST_WORD) w_state_next = S_FINISH;
                    else                                                  w_state_next = S_SEND;
                end
            end
            S_FINISH:  w_state_next = S_CAPTURE;
            default:   w_state_next = S_CAPTURE;
        endcase
    end

    always_comb begin
        w_wr_idx_next   = r_wr_idx;
        w_rd_idx_next   = r_rd_idx;
        w_byte_idx_next = r_byte_idx;
        w_tx_dv_next    = 1'b0;
        w_tx_byte_next  = r_tx_byte;
        w_done_next     = 1'b0;
        w_buf_we        = 1'b0;
        w_busy_next     = (w_state_next == S_SEND) || (w_state_next == S_WAIT);
        // Any word offered while not capturing is lost; flag it until reset.
        w_overflow_next = r_overflow || (result_valid_i && r_state != S_CAPTURE);
        unique case (r_state)
            S_CAPTURE: begin
                if (result_valid_i) begin
                    w_buf_we      = !rst;
                    w_wr_idx_next = (r_wr_idx == LAST_WORD) ? '0 : r_wr_idx + RW'(1);
                end
            end
            S_SEND: begin
                if (!tx_active_i) begin
                    w_tx_dv_next   = 1'b1;
                    w_tx_byte_next = w_rd_shifted[7:0];
                end
            end
            S_WAIT: begin
                if (tx_done_i) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_byte_idx_next = r_byte_idx + BW'(1);
                    end else begin
                        w_byte_idx_next = '0;
                        w_rd_idx_next   = (r_rd_idx == LAST_WORD) ? '0 : r_rd_idx + RW'(1);
                    end
                end
            end
            S_FINISH:  w_done_next = 1'b1;
            default:   ;
        endcase
    end

    assign tx_dv_o    = r_tx_dv;
    assign tx_byte_o  = r_tx_byte;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign overflow_o = r_overflow;
endmodule

// File: tb/tb_ntt_result_uart_sender.sv
// Self-checking bench: frame-level scoreboard of expected bytes, a uart_tx timing model,
// and a per-cycle compare of busy/done/overflow and every launched byte.
module tb_ntt_result_uart_sender;
    localparam int W     = 32;
    localparam int RADIX = 16;
    localparam int BYTES = W / 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         result_valid_i = 1'b0;
    logic [W-1:0] result_data_i = '0;
    logic         tx_active_i;
    logic         tx_done_i = 1'b0;
    logic         tx_dv_o;
    logic [7:0]   tx_byte_o;
    logic         busy_o;
    logic         done_o;
    logic         overflow_o;

    logic uart_active = 1'b0;
    logic hold_active = 1'b0;
    int   uart_lat    = 10;
    assign tx_active_i = uart_active | hold_active;

    ntt_result_uart_sender #(.W(W), .RADIX(RADIX)) dut (
        .clk(clk), .rst(rst),
        .result_valid_i(result_valid_i), .result_data_i(result_data_i),
        .tx_active_i(tx_active_i), .tx_done_i(tx_done_i),
        .tx_dv_o(tx_dv_o), .tx_byte_o(tx_byte_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int dv_count = 0;
    int done_count = 0;
    bit compare_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: collects words into a frame, and once a frame is complete queues
    // its bytes little-endian; transmission ends after RADIX*BYTES completed bytes.
    typedef enum {M_CAP, M_TX, M_FIN} mode_t;
    mode_t        mode = M_CAP;
    int           cnt = 0;
    int           bytes_left = 0;
    logic [W-1:0] frame [RADIX];
    logic [7:0]   q [$];
    logic         exp_ovf = 1'b0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    logic         active_at_edge = 1'b0;

    always @(posedge clk) active_at_edge = tx_active_i;

    always @(posedge clk) begin
        if (rst) begin
            mode = M_CAP; cnt = 0; bytes_left = 0;
            exp_ovf = 1'b0; exp_done = 1'b0;
            q.delete();
        end else begin
            exp_done = (mode == M_FIN);
            case (mode)
                M_CAP: begin
                    if (result_valid_i) begin
                        frame[cnt] = result_data_i;
                        cnt++;
                        if (cnt == RADIX) begin
                            for (int i = 0; i < RADIX; i++)
                                for (int b = 0; b < BYTES; b++)
                                    q.push_back(frame[i][8*b +: 8]);
                            bytes_left = RADIX * BYTES;
                            cnt = 0;
                            mode = M_TX;
                        end
                    end
                end
                M_TX: begin
                    if (result_valid_i) exp_ovf = 1'b1;
                    if (tx_done_i) begin
                        bytes_left--;
                        if (bytes_left == 0) mode = M_FIN;
                    end
                end
                default: begin
                    if (result_valid_i) exp_ovf = 1'b1;
                    mode = M_CAP;
                end
            endcase
        end
        exp_busy = (mode == M_TX);
    end

    // uart_tx model: busy for uart_lat cycles after each launch, then a one-cycle done.
    int busy_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0; uart_active = 1'b0; tx_done_i = 1'b0;
        end else begin
            tx_done_i = 1'b0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    uart_active = 1'b0;
                    tx_done_i   = 1'b1;
                end
            end
            if (tx_dv_o) begin
                uart_active = 1'b1;
                busy_cnt    = uart_lat;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            check("busy_o", busy_o, exp_busy);
            check("done_o", done_o, exp_done);
            check("overflow_o", overflow_o, exp_ovf);
            if (tx_dv_o) begin
                dv_count++;
                check("dv_while_active", active_at_edge, 1'b0);
                if (q.size() == 0) begin
                    fail_now("unexpected_tx_dv");
                end else begin
                    logic [7:0] eb;
                    eb = q.pop_front();
                    check("tx_byte_o", tx_byte_o, eb);
                end
            end
            if (done_o) done_count++;
        end
    end

    task automatic send_word(input logic [W-1:0] d);
        result_valid_i = 1'b1;
        result_data_i  = d;
        @(negedge clk);
        result_valid_i = 1'b0;
    endtask

    task automatic send_random_frame();
        for (int i = 0; i < RADIX; i++) begin
            send_word($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int  start;
        bit  seen;
        start = done_count;
        seen  = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk);
            if (done_count > start) seen = 1'b1;
        end
        if (!seen) fail_now("timeout_waiting_done");
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_dv", tx_dv_o, 1'b0);
        check("rst_tx_byte", tx_byte_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        compare_en = 1'b1;
        rst = 1'b0;

        // Incrementing frame: bytes must come out as 0x00..0x3F
        for (int i = 0; i < RADIX; i++) send_word(32'h03020100 + 32'h04040404 * i);
        check("model_queue_size", q.size(), RADIX * BYTES);
        for (int k = 0; k < RADIX * BYTES && k < q.size(); k++) check("model_byte", q[k], k);
        wait_done();
        check("frame1_done_count", done_count, 1);
        check("frame1_busy_after", busy_o, 1'b0);

        // tx_active held high at the start of SEND
        begin
            int base;
            hold_active = 1'b1;
            send_random_frame();
            base = dv_count;
            repeat (50) @(posedge clk);
            check("held_no_dv", dv_count - base, 0);
            @(negedge clk);
            hold_active = 1'b0;
            repeat (3) @(posedge clk);
            check("one_pulse_after_release", dv_count - base, 1);
            wait_done();
        end

        // Extra word while transmitting
        send_random_frame();
        repeat (20) @(negedge clk);
        send_word($urandom);
        wait_done();
        check("overflow_sticky", overflow_o, 1'b1);

        // Reset after the fifth byte of a frame
        begin
            int base;
            bit reached;
            send_random_frame();
            base    = dv_count;
            reached = 1'b0;
            for (int i = 0; i < 2000 && !reached; i++) begin
                @(posedge clk);
                if (dv_count >= base + 5) reached = 1'b1;
            end
            if (!reached) fail_now("timeout_waiting_5_bytes");
            @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            check("rst_mid_tx_dv", tx_dv_o, 1'b0);
            check("rst_mid_busy", busy_o, 1'b0);
            check("rst_mid_overflow", overflow_o, 1'b0);
            rst = 1'b0;
            send_random_frame();
            wait_done();
        end

        // Back-to-back frames, second starting the cycle after done_o
        begin
            bit seen;
            send_random_frame();
            seen = 1'b0;
            for (int i = 0; i < 5000 && !seen; i++) begin
                @(negedge clk);
                if (done_o) seen = 1'b1;
            end
            if (!seen) fail_now("timeout_b2b_first_done");
            for (int i = 0; i < RADIX; i++) send_word($urandom);
            wait_done();
            check("b2b_overflow", overflow_o, 1'b0);
        end

        // Random frames with random uart latency
        for (int f = 0; f < 3; f++) begin
            uart_lat = $urandom_range(1, 12);
            send_random_frame();
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("done_total", done_count, 9);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
